// File: rtl/pwm_ramp_pkg.sv
// Shared types and default widths for the PWM duty ramp controller.
package pwm_ramp_pkg;

  localparam int PWM_SIZE_DEF = 32;
  localparam int DIV_W_DEF    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter: counts 0..period-1 and flags the last cycle.
module pwm_period_tick
  import pwm_ramp_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [PWM_SIZE-1:0] period,
  output logic                tick
);

  logic [PWM_SIZE-1:0] cnt_q, cnt_d;
  logic                short_period;

  // A period of 0 or 1 has no room to count, so every cycle is the last one.
  assign short_period = (period <= PWM_SIZE'(1));
  assign tick         = short_period || (cnt_q == period - PWM_SIZE'(1));

  always_comb begin
    cnt_d = cnt_q + PWM_SIZE'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM duty value toward a target in steps aligned to period boundaries.
// Define PWM_RAMP_CLAMP_EN to clamp an accepted target to the accepted period.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PWM_SIZE-1:0] cfg_period,
  input  logic [PWM_SIZE-1:0] cfg_target,
  input  logic [PWM_SIZE-1:0] cfg_step,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                abort,
  output logic [PWM_SIZE-1:0] pwm_period,
  output logic [PWM_SIZE-1:0] pwm_duty,
  output logic                period_tick,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [PWM_SIZE-1:0] period_q, period_d;
  logic [PWM_SIZE-1:0] duty_q, duty_d;
  logic [PWM_SIZE-1:0] target_q, target_d;
  logic [PWM_SIZE-1:0] step_q, step_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                done_q, done_d;

  logic                accept;
  logic [PWM_SIZE-1:0] target_lat;
  logic [PWM_SIZE-1:0] diff;
  logic                going_up;
  logic                div_last;
  logic                complete;

  assign accept = (state_q == ST_IDLE) && cfg_valid;

`ifdef PWM_RAMP_CLAMP_EN
  assign target_lat = (cfg_target > cfg_period) ? cfg_period : cfg_target;
`else
  assign target_lat = cfg_target;
`endif

  // Magnitude taken by ordered subtraction so it never wraps.
  assign going_up = (target_q >= duty_q);
  assign diff     = going_up ? (target_q - duty_q) : (duty_q - target_q);
  // div_q is always at least 1 while ramping, so the subtraction cannot underflow there.
  assign div_last = (div_cnt_q == div_q - DIV_W'(1));

  pwm_period_tick #(
    .PWM_SIZE(PWM_SIZE)
  ) u_period_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .period(period_q),
    .tick  (period_tick)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    complete  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          period_d  = cfg_period;
          target_d  = target_lat;
          step_d    = cfg_step;
          div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
          div_cnt_d = '0;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (period_tick) begin
          if (duty_q == target_q) begin
            complete = 1'b1;
          end else if (div_last) begin
            div_cnt_d = '0;
            if ((step_q == '0) || (diff <= step_q)) begin
              duty_d   = target_q;
              complete = 1'b1;
            end else if (going_up) begin
              duty_d = duty_q + step_q;
            end else begin
              duty_d = duty_q - step_q;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        // A completing step takes precedence over a simultaneous abort.
        if (complete || abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = complete;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      duty_q    <= '0;
      target_q  <= '0;
      step_q    <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = ~cfg_ready;
  assign done       = done_q;
  assign pwm_period = period_q;
  assign pwm_duty   = duty_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed vector table, corner sequences, random traffic vs model.
module tb_pwm_ramp_ctrl;

  localparam int PW = 16;
  localparam int DW = 8;

`ifdef PWM_RAMP_CLAMP_EN
  localparam int CLAMP_DUTY = 8;
`else
  localparam int CLAMP_DUTY = 50;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_period;
  logic [PW-1:0] cfg_target;
  logic [PW-1:0] cfg_step;
  logic [DW-1:0] cfg_div;
  logic          abort;
  logic [PW-1:0] pwm_period;
  logic [PW-1:0] pwm_duty;
  logic          period_tick;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .PWM_SIZE(PW),
    .DIV_W   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_div    (cfg_div),
    .abort      (abort),
    .pwm_period (pwm_period),
    .pwm_duty   (pwm_duty),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc_no  = 0;

  // Reference model: ramp bookkeeping in plain integers, ticks derived from elapsed cycles.
  bit     m_busy, m_done;
  longint m_period, m_duty, m_target, m_step, m_div, m_cyc, m_ticks;

  function automatic bit m_tick();
    if (m_period <= 1) return 1'b1;
    return (m_cyc % m_period) == (m_period - 1);
  endfunction

  task automatic model_advance();
    bit     tk;
    bit     fin;
    longint d;
    longint ad;
    tk  = m_tick();
    fin = 1'b0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_period = 0; m_duty = 0;
      m_target = 0; m_step = 0; m_div = 1; m_cyc = 0; m_ticks = 0;
      return;
    end
    m_done = 0;
    m_cyc  = m_cyc + 1;
    if (!m_busy) begin
      if (cfg_valid) begin
        m_busy   = 1;
        m_period = cfg_period;
        m_target = cfg_target;
`ifdef PWM_RAMP_CLAMP_EN
        if (m_target > m_period) m_target = m_period;
`endif
        m_step  = cfg_step;
        m_div   = (cfg_div == 0) ? 1 : cfg_div;
        m_cyc   = 0;
        m_ticks = 0;
      end
    end else begin
      if (tk) begin
        m_ticks = m_ticks + 1;
        if (m_duty == m_target) begin
          fin = 1;
        end else if (m_ticks % m_div == 0) begin
          d  = m_target - m_duty;
          ad = (d < 0) ? -d : d;
          if (m_step == 0 || ad <= m_step) begin
            m_duty = m_target;
            fin    = 1;
          end else begin
            m_duty = (d > 0) ? m_duty + m_step : m_duty - m_step;
          end
        end
      end
      if (fin) begin
        m_done = 1;
        m_busy = 0;
      end else if (abort) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [2*PW+3:0] got, exp;
    got = {cfg_ready, busy, done, period_tick, pwm_period, pwm_duty};
    exp = {~m_busy, m_busy, m_done, m_tick(), m_period[PW-1:0], m_duty[PW-1:0]};
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model cyc=%0d got rdy=%0b busy=%0b done=%0b tick=%0b per=%0d duty=%0d want rdy=%0b busy=%0b done=%0b tick=%0b per=%0d duty=%0d",
               cyc_no, cfg_ready, busy, done, period_tick, pwm_period, pwm_duty,
               ~m_busy, m_busy, m_done, m_tick(), m_period[PW-1:0], m_duty[PW-1:0]);
    end
  endtask

  task automatic do_cycle();
    model_advance();
    @(posedge clk);
    #1;
    cyc_no++;
    check_model();
  endtask

  task automatic check_val(input string name, input longint got, input longint want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  typedef struct {
    int n;
    bit valid;
    bit abt;
    int per;
    int tgt;
    int stp;
    int dv;
    int e_duty;
    int e_period;
    bit e_busy;
    bit e_done;
    bit e_tick;
  } vec_t;

  function automatic vec_t mk(input int n, input bit valid, input bit abt, input int per,
                              input int tgt, input int stp, input int dv, input int e_duty,
                              input int e_period, input bit e_busy, input bit e_done, input bit e_tick);
    vec_t v;
    v.n = n; v.valid = valid; v.abt = abt; v.per = per; v.tgt = tgt; v.stp = stp; v.dv = dv;
    v.e_duty = e_duty; v.e_period = e_period; v.e_busy = e_busy; v.e_done = e_done; v.e_tick = e_tick;
    return v;
  endfunction

  vec_t vecs[$];
  int   n_ready_seen;
  int   n_done_seen;
  int   len;

  initial begin
    // n, valid, abort, period, target, step, div -> duty, period, busy, done, tick
    vecs.push_back(mk( 1, 1, 0, 10, 30, 10, 1,  0, 10, 1, 0, 0)); // up-ramp accepted
    vecs.push_back(mk( 9, 0, 0, 10, 30, 10, 1,  0, 10, 1, 0, 1)); // last cycle of period 1
    vecs.push_back(mk( 1, 0, 0, 10, 30, 10, 1, 10, 10, 1, 0, 0));
    vecs.push_back(mk(10, 0, 0, 10, 30, 10, 1, 20, 10, 1, 0, 0));
    vecs.push_back(mk(10, 0, 0, 10, 30, 10, 1, 30, 10, 0, 1, 0)); // done with final update
    vecs.push_back(mk( 1, 0, 0, 10, 30, 10, 1, 30, 10, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0, 10,  5, 10, 2, 30, 10, 1, 0, 0)); // down-ramp, div=2
    vecs.push_back(mk(10, 0, 0, 10,  5, 10, 2, 30, 10, 1, 0, 0));
    vecs.push_back(mk(10, 0, 0, 10,  5, 10, 2, 20, 10, 1, 0, 0));
    vecs.push_back(mk(20, 0, 0, 10,  5, 10, 2, 10, 10, 1, 0, 0));
    vecs.push_back(mk(20, 0, 0, 10,  5, 10, 2,  5, 10, 0, 1, 0)); // partial last step
    vecs.push_back(mk( 1, 0, 0, 10,  5, 10, 2,  5, 10, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0, 10, 40, 15, 1,  5, 10, 1, 0, 0));
    vecs.push_back(mk(10, 0, 0, 10, 40, 15, 1, 20, 10, 1, 0, 0));
    vecs.push_back(mk( 1, 0, 1, 10, 40, 15, 1, 20, 10, 0, 0, 0)); // abort holds duty
    vecs.push_back(mk(12, 0, 0, 10, 40, 15, 1, 20, 10, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 1, 10,  7,  0, 1, 20, 10, 1, 0, 0)); // abort ignored in idle
    vecs.push_back(mk(10, 0, 0, 10,  7,  0, 1,  7, 10, 0, 1, 0)); // step=0 jumps
    vecs.push_back(mk( 1, 1, 0,  4,  9,  1, 0,  7,  4, 1, 0, 0)); // div=0 acts as 1
    vecs.push_back(mk( 4, 0, 0,  4,  9,  1, 0,  8,  4, 1, 0, 0));
    vecs.push_back(mk( 4, 0, 0,  4,  9,  1, 0,  9,  4, 0, 1, 0));
    vecs.push_back(mk( 1, 1, 0,  1, 12,  2, 1,  9,  1, 1, 0, 1)); // period=1
    vecs.push_back(mk( 1, 0, 0,  1, 12,  2, 1, 11,  1, 1, 0, 1));
    vecs.push_back(mk( 1, 0, 0,  1, 12,  2, 1, 12,  1, 0, 1, 1));
    vecs.push_back(mk( 1, 1, 0,  8, 50,  0, 1, 12,  8, 1, 0, 0)); // target above period
    vecs.push_back(mk( 8, 0, 0,  8, 50,  0, 1, CLAMP_DUTY, 8, 0, 1, 0));
    vecs.push_back(mk( 1, 0, 0,  8, 50,  0, 1, CLAMP_DUTY, 8, 0, 0, 0));

    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_period = '0; cfg_target = '0; cfg_step = '0; cfg_div = '0;
    do_cycle();
    do_cycle();
    check_val("rst_duty", pwm_duty, 0);
    check_val("rst_period", pwm_period, 0);
    check_val("rst_ready", cfg_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_tick", period_tick, 1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_valid  = vecs[i].valid;
      abort      = vecs[i].abt;
      cfg_period = PW'(vecs[i].per);
      cfg_target = PW'(vecs[i].tgt);
      cfg_step   = PW'(vecs[i].stp);
      cfg_div    = DW'(vecs[i].dv);
      repeat (vecs[i].n) do_cycle();
      check_val($sformatf("vec%0d_duty", i), pwm_duty, vecs[i].e_duty);
      check_val($sformatf("vec%0d_period", i), pwm_period, vecs[i].e_period);
      check_val($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check_val($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      check_val($sformatf("vec%0d_tick", i), period_tick, vecs[i].e_tick);
      $display("vec %0d: duty=%0d period=%0d busy=%0b done=%0b", i, pwm_duty, pwm_period, busy, done);
    end
    cfg_valid = 1'b0;
    abort     = 1'b0;

    // Reset in the middle of a ramp.
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_period = 10; cfg_target = 30; cfg_step = 10; cfg_div = 1;
    do_cycle();
    cfg_valid = 1'b0;
    repeat (20) do_cycle();
    check_val("midrst_pre_duty", pwm_duty, 20);
    check_val("midrst_pre_busy", busy, 1);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    check_val("midrst_duty", pwm_duty, 0);
    check_val("midrst_period", pwm_period, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_tick", period_tick, 1);
    $display("midrst: duty=%0d period=%0d busy=%0b", pwm_duty, pwm_period, busy);

    // cfg_valid held high: each idle cycle (one after every done) accepts exactly once.
    cfg_valid = 1'b1; cfg_period = 3; cfg_target = 30; cfg_step = 10; cfg_div = 1;
    n_ready_seen = 0;
    n_done_seen  = 0;
    repeat (40) begin
      do_cycle();
      if (cfg_ready) n_ready_seen++;
      if (done) n_done_seen++;
    end
    cfg_valid = 1'b0;
    check_val("hold_ready_cycles", n_ready_seen, 8);
    check_val("hold_done_pulses", n_done_seen, 8);
    $display("hold: ready_cycles=%0d done_pulses=%0d", n_ready_seen, n_done_seen);

    // Random traffic against the model.
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_period = PW'($urandom_range(1, 3));
        cfg_target = PW'($urandom_range(0, 16'hFFFF));
        cfg_step   = PW'($urandom_range(16'h1000, 16'hFFFF));
        cfg_div    = DW'($urandom_range(0, 2));
      end else begin
        cfg_period = PW'($urandom_range(0, 6));
        cfg_target = PW'($urandom_range(0, 40));
        cfg_step   = PW'($urandom_range(0, 15));
        cfg_div    = DW'($urandom_range(0, 3));
      end
      cfg_valid = 1'b1;
      abort     = ($urandom_range(0, 15) == 0);
      do_cycle();
      cfg_valid = 1'b0;
      len = $urandom_range(2, 50);
      repeat (len) begin
        abort = ($urandom_range(0, 39) == 0);
        rst   = ($urandom_range(0, 299) == 0);
        do_cycle();
      end
      rst   = 1'b0;
      abort = 1'b0;
      $display("txn %0d: per=%0d tgt=%0d step=%0d div=%0d -> duty=%0d busy=%0b",
               t, cfg_period, cfg_target, cfg_step, cfg_div, pwm_duty, busy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter PWM_SIZE, default 32: width of period, duty, target and step values.
REQ-002 Parameter DIV_W, default 16: width of the step-interval divider.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  ramp request present.
REQ-006 cfg_ready  output  1  request accepted when cfg_valid && cfg_ready.
REQ-007 cfg_period  input  PWM_SIZE  PWM period in clk cycles for the ramp.
REQ-008 cfg_target  input  PWM_SIZE  final duty value.
REQ-009 cfg_step  input  PWM_SIZE  duty increment per step; 0 means jump straight to target.
REQ-010 cfg_div  input  DIV_W  PWM periods per step; 0 is treated as 1.
REQ-011 abort  input  1  stop the active ramp, hold the current duty.
REQ-012 pwm_period  output  PWM_SIZE  period for the downstream pwm_driver.
REQ-013 pwm_duty  output  PWM_SIZE  duty for the downstream pwm_driver.
REQ-014 period_tick  output  1  one-cycle pulse on the last cycle of each PWM period.
REQ-015 busy  output  1  ramp in progress.
REQ-016 done  output  1  one-cycle pulse when the ramp reaches its target.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and RAMP.
REQ-018 cfg_ready SHALL equal 1 in IDLE and 0 in RAMP; busy SHALL be the inverse of cfg_ready.
REQ-019 On acceptance, the block SHALL perform the following in the next cycle:
- load cfg_period into pwm_period;
- latch target, step and div;
- clear the period and div counters;
- enter RAMP.
REQ-020 pwm_duty SHALL NOT change on acceptance; the ramp starts from the duty currently held.
REQ-021 The period counter SHALL count 0..pwm_period-1 and wrap to 0.
REQ-022 period_tick SHALL assert when the counter equals pwm_period-1; if pwm_period<=1, period_tick SHALL be high every cycle.
REQ-023 In RAMP, the div counter SHALL increment on each period_tick; a step event SHALL occur on the period_tick that completes div periods, after which the div counter clears.
REQ-024 On a step event, |target-duty| SHALL be computed without overflow, and the duty update registered in the same cycle (visible the next cycle):
- if the difference <= step, or step==0, duty becomes target;
- otherwise duty moves one step toward target.
REQ-025 pwm_duty SHALL change only on cycles where period_tick=1, so updates never land mid-period.
REQ-026 On the step event that makes duty equal target, or on the first period_tick in RAMP if duty already equals target, done SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-027 abort in RAMP SHALL return the FSM to IDLE next cycle, hold pwm_duty and pwm_period, and not pulse done.
REQ-028 abort in IDLE SHALL be ignored; cfg_valid with abort in IDLE SHALL be accepted normally.
REQ-029 abort and a completing step event in the same cycle: completion wins (duty updates, done pulses).
REQ-030 cfg_valid in RAMP SHALL be held off by cfg_ready=0 and not dropped by the block.

Reset
REQ-031 On rst, the block SHALL reset to:
- state IDLE;
- pwm_period=0, pwm_duty=0;
- cfg_ready=1, busy=0, done=0;
- period and div counters at 0.
REQ-032 period_tick SHALL be 1 during reset, since pwm_period=0.
REQ-033 rst mid-ramp SHALL take priority over all inputs and SHALL NOT pulse done.

Configuration
REQ-034 With PWM_RAMP_CLAMP_EN defined, a cfg_target greater than cfg_period SHALL be latched as cfg_period.
REQ-035 Without PWM_RAMP_CLAMP_EN, cfg_target SHALL be latched unmodified.

Structure
REQ-036 Package pwm_ramp_pkg SHALL hold the FSM state enum typedef and the default PWM_SIZE/DIV_W constants.
REQ-037 The period counter and period_tick SHALL be a sub-module, pwm_period_tick, with inputs clk, rst, clr and period, and output tick.
REQ-038 The block SHALL NOT instantiate pwm_driver; pwm_period/pwm_duty connect to it at the level above.

Verification
REQ-039 Up-ramp: from reset, accept period=10, target=30, step=10, div=1 -> pwm_duty goes 10, 20, 30, one cycle after successive period_ticks (every 10 cycles); done pulses once with the 30 update; then cfg_ready=1.
REQ-040 Down-ramp with a partial last step: duty=30, accept target=5, step=10, div=2 -> duty goes 20, 10, 5, each update every 2nd period_tick; done pulses once.
REQ-041 Abort: during the up-ramp with duty=20, assert abort -> IDLE next cycle, duty stays 20, done stays 0, pwm_period stays 10.
REQ-042 Degenerate inputs: accept step=0 with target=7 -> duty=7 after the first period_tick plus done; accept cfg_div=0 -> behaves as div=1; accept period=1 -> period_tick high every cycle.
REQ-043 Clamp: accept period=8, target=50 -> final duty is 8 with PWM_RAMP_CLAMP_EN defined, 50 without.
REQ-044 Reset mid-ramp: assert rst while duty=20 in RAMP -> next cycle all outputs at reset values and no done pulse; then cfg_valid held high through a ramp -> exactly one acceptance per IDLE visit.
